// File: rtl/data_mem_responder_if.sv
// CPU data-memory port: the MEM stage drives the request, the responder returns
// same-cycle read data, the timer interrupt request and the bus error pulse.
interface data_mem_responder_if;
    logic        mem_enable_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        req_interrupt_timer_o;
    logic        bus_err_o;

    // CPU side
    modport master (
        output mem_enable_i,
        output mem_we_i,
        output mem_addr_i,
        output mem_wdata_i,
        input  mem_rdata_o,
        input  req_interrupt_timer_o,
        input  bus_err_o
    );

    // Memory side
    modport slave (
        input  mem_enable_i,
        input  mem_we_i,
        input  mem_addr_i,
        input  mem_wdata_i,
        output mem_rdata_o,
        output req_interrupt_timer_o,
        output bus_err_o
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM at address 0, a four-register timer window at
// TIMER_BASE, and a registered error pulse for accesses that hit neither.
module data_mem_responder #(
    parameter int unsigned RAM_WORDS  = 1024,
    parameter logic [31:0] TIMER_BASE = 32'h0001_0000
) (
    input logic                clk,
    input logic                reset,
    data_mem_responder_if.slave bus
);
    localparam int unsigned IdxW     = $clog2(RAM_WORDS);
    localparam logic [31:0] RamBytes = 32'(RAM_WORDS * 4);

    typedef enum logic [1:0] {
        RegCtrl    = 2'd0,
        RegCount   = 2'd1,
        RegCompare = 2'd2,
        RegStatus  = 2'd3
    } reg_sel_e;

    logic [31:0] ram_q [RAM_WORDS];

    logic [2:0]  ctrl_q;      // {AUTO_RELOAD, IRQ_EN, EN}
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        pending_q;
    logic        bus_err_q;

    logic            ram_hit;
    logic            timer_hit;
    logic [IdxW-1:0] ram_idx;
    reg_sel_e        reg_sel;
    logic            ram_wr;
    logic            timer_wr;
    logic            match;
    logic [31:0]     rdata;

    // Address decode and access qualification
    always_comb begin
        ram_hit   = bus.mem_addr_i < RamBytes;
        timer_hit = bus.mem_addr_i[31:4] == TIMER_BASE[31:4];
        ram_idx   = bus.mem_addr_i[IdxW+1:2];
        reg_sel   = reg_sel_e'(bus.mem_addr_i[3:2]);
        ram_wr    = bus.mem_enable_i && bus.mem_we_i && ram_hit;
        timer_wr  = bus.mem_enable_i && bus.mem_we_i && timer_hit;
        match     = ctrl_q[0] && (count_q == compare_q);
    end

    // RAM write port; not gated by reset so a write during reset still lands
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            ram_q[ram_idx] <= bus.mem_wdata_i;
        end
    end

    // Same-cycle read mux; zero for writes, idle cycles, unmapped hits and reset
    always_comb begin
        rdata = '0;
        if (reset && bus.mem_enable_i && !bus.mem_we_i) begin
            if (ram_hit) begin
                rdata = ram_q[ram_idx];
            end else if (timer_hit) begin
                unique case (reg_sel)
                    RegCtrl:    rdata = {29'd0, ctrl_q};
                    RegCount:   rdata = count_q;
                    RegCompare: rdata = compare_q;
                    RegStatus:  rdata = {31'd0, pending_q};
                    default:    rdata = '0;
                endcase
            end
        end
    end

    // Timer state and error pulse; CPU writes to COUNT beat the increment,
    // a match beats a STATUS clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_q    <= '0;
            count_q   <= '0;
            compare_q <= 32'hFFFF_FFFF;
            pending_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= bus.mem_enable_i && !ram_hit && !timer_hit;

            if (timer_wr && reg_sel == RegCtrl) begin
                ctrl_q <= bus.mem_wdata_i[2:0];
            end

            if (timer_wr && reg_sel == RegCompare) begin
                compare_q <= bus.mem_wdata_i;
            end

            if (timer_wr && reg_sel == RegCount) begin
                count_q <= bus.mem_wdata_i;
            end else if (ctrl_q[0]) begin
                count_q <= (match && ctrl_q[2]) ? '0 : count_q + 32'd1;
            end

            if (match) begin
                pending_q <= 1'b1;
            end else if (timer_wr && reg_sel == RegStatus && bus.mem_wdata_i[0]) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign bus.mem_rdata_o           = rdata;
    assign bus.bus_err_o             = bus_err_q;
    assign bus.req_interrupt_timer_o = pending_q & ctrl_q[1];
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios with literal expectations,
// then random traffic checked cycle by cycle against a behavioural model.
module tb_data_mem_responder;
    localparam int unsigned RamWords  = 1024;
    localparam logic [31:0] TimerBase = 32'h0001_0000;
    localparam logic [31:0] ACtrl     = TimerBase + 32'h0;
    localparam logic [31:0] ACount    = TimerBase + 32'h4;
    localparam logic [31:0] ACompare  = TimerBase + 32'h8;
    localparam logic [31:0] AStatus   = TimerBase + 32'hC;

    logic clk = 1'b0;
    logic reset;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .RAM_WORDS (RamWords),
        .TIMER_BASE(TimerBase)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic [31:0] m_ram    [RamWords];
    bit          m_ram_ok [RamWords];
    logic [2:0]  m_ctrl    = 3'd0;
    logic [31:0] m_count   = 32'd0;
    logic [31:0] m_compare = 32'hFFFF_FFFF;
    bit          m_pending = 1'b0;
    bit          m_err     = 1'b0;

    // Last observed outputs
    logic [31:0] obs_rd;
    logic        obs_irq;
    logic        obs_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected read data; returns 0 when the RAM word has never been written
    function automatic bit model_read(input bit rst_n, input bit en, input bit we,
                                      input logic [31:0] a, output logic [31:0] d);
        d = 32'd0;
        if (!rst_n || !en || we) return 1'b1;
        if (a < RamWords * 4) begin
            d = m_ram[int'(a >> 2)];
            return m_ram_ok[int'(a >> 2)];
        end
        if (a[31:4] == TimerBase[31:4]) begin
            case (a[3:2])
                2'd0: d = {29'd0, m_ctrl};
                2'd1: d = m_count;
                2'd2: d = m_compare;
                default: d = {31'd0, m_pending};
            endcase
        end
        return 1'b1;
    endfunction

    // Advance the model by one clock edge
    task automatic model_step(input bit rst_n, input bit en, input bit we,
                              input logic [31:0] a, input logic [31:0] wd);
        bit          is_ram;
        bit          is_tmr;
        bit          hit_cmp;
        logic [31:0] cnt_next;
        bit          pend_next;
        is_ram = a < RamWords * 4;
        is_tmr = a[31:4] == TimerBase[31:4];
        if (en && we && is_ram) begin
            m_ram[int'(a >> 2)]    = wd;
            m_ram_ok[int'(a >> 2)] = 1'b1;
        end
        if (!rst_n) begin
            m_ctrl = 3'd0; m_count = 32'd0; m_compare = 32'hFFFF_FFFF;
            m_pending = 1'b0; m_err = 1'b0;
            return;
        end
        m_err     = en && !is_ram && !is_tmr;
        hit_cmp   = m_ctrl[0] && (m_count == m_compare);
        cnt_next  = m_count;
        if (m_ctrl[0]) cnt_next = (hit_cmp && m_ctrl[2]) ? 32'd0 : m_count + 32'd1;
        pend_next = m_pending;
        if (en && we && is_tmr && a[3:2] == 2'd3 && wd[0]) pend_next = 1'b0;
        if (hit_cmp) pend_next = 1'b1;
        if (en && we && is_tmr) begin
            case (a[3:2])
                2'd0: m_ctrl = wd[2:0];
                2'd1: cnt_next = wd;
                2'd2: m_compare = wd;
                default: ;
            endcase
        end
        m_count   = cnt_next;
        m_pending = pend_next;
    endtask

    // One bus cycle: drive, sample mid-cycle against the model, then clock
    task automatic access(input bit en, input bit we, input logic [31:0] a,
                          input logic [31:0] wd);
        logic [31:0] exp_rd;
        bit          known;
        bus.mem_enable_i = en;
        bus.mem_we_i     = we;
        bus.mem_addr_i   = a;
        bus.mem_wdata_i  = wd;
        @(negedge clk);
        obs_rd  = bus.mem_rdata_o;
        obs_irq = bus.req_interrupt_timer_o;
        obs_err = bus.bus_err_o;
        known   = model_read(reset, en, we, a, exp_rd);
        if (known) check("rdata", obs_rd, exp_rd);
        check("irq", {31'd0, obs_irq}, {31'd0, m_pending && m_ctrl[1]});
        check("bus_err", {31'd0, obs_err}, {31'd0, m_err});
        @(posedge clk);
        model_step(reset, en, we, a, wd);
        #1;
    endtask

    task automatic rd(input logic [31:0] a);
        access(1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        access(1'b1, 1'b1, a, d);
    endtask

    task automatic idle();
        access(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        bit          en;
        bit          we;

        reset = 1'b0;
        bus.mem_enable_i = 1'b0;
        bus.mem_we_i     = 1'b0;
        bus.mem_addr_i   = 32'd0;
        bus.mem_wdata_i  = 32'd0;
        @(posedge clk);
        model_step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        idle();
        check("reset_irq", {31'd0, obs_irq}, 32'd0);
        check("reset_err", {31'd0, obs_err}, 32'd0);
        reset = 1'b1;
        rd(ACompare);
        check("reset_compare", obs_rd, 32'hFFFF_FFFF);

        // RAM write/read
        wr(32'h10, 32'hDEAD_BEEF);
        wr(32'hFFC, 32'h1234_5678);
        rd(32'h10);  check("ram_10", obs_rd, 32'hDEAD_BEEF);
        rd(32'hFFC); check("ram_last", obs_rd, 32'h1234_5678);
        rd(32'h13);  check("ram_lowbits", obs_rd, 32'hDEAD_BEEF);

        // Unmapped access
        wr(32'h0, 32'hAAAA_5555);
        rd(32'h2000); check("unmapped_rd", obs_rd, 32'd0);
        idle();       check("err_pulse", {31'd0, obs_err}, 32'd1);
        idle();       check("err_gone", {31'd0, obs_err}, 32'd0);
        wr(32'h2000, 32'h0);
        rd(32'h2000);
        rd(32'h0);    check("ram0_kept", obs_rd, 32'hAAAA_5555);
        check("err_b2b", {31'd0, obs_err}, 32'd1);

        // Timer one-shot
        wr(ACompare, 32'd5);
        wr(ACount, 32'd0);
        wr(ACtrl, 32'd3);
        for (int i = 0; i < 8; i++) begin
            rd(ACount);
            check("oneshot_count", obs_rd, 32'(i));
            check("oneshot_irq", {31'd0, obs_irq}, {31'd0, i >= 6});
        end
        wr(AStatus, 32'd1);
        idle(); check("irq_cleared", {31'd0, obs_irq}, 32'd0);

        // Auto-reload and clear colliding with a match
        wr(ACtrl, 32'd0);
        wr(ACount, 32'd0);
        wr(ACompare, 32'd3);
        wr(AStatus, 32'd1);
        wr(ACtrl, 32'd7);
        for (int i = 0; i < 10; i++) begin
            rd(ACount);
            check("reload_count", obs_rd, 32'(i % 4));
            check("reload_irq", {31'd0, obs_irq}, {31'd0, i >= 4});
        end
        wr(AStatus, 32'd1);
        wr(AStatus, 32'd1);
        check("clr_took", {31'd0, obs_irq}, 32'd0);
        rd(AStatus); check("set_wins", obs_rd, 32'd1);

        // Wrap and COUNT write priority
        wr(ACtrl, 32'd0);
        wr(ACount, 32'hFFFF_FFFE);
        wr(ACompare, 32'd0);
        wr(AStatus, 32'd1);
        wr(ACtrl, 32'd1);
        rd(ACount); check("wrap0", obs_rd, 32'hFFFF_FFFE);
        rd(ACount); check("wrap1", obs_rd, 32'hFFFF_FFFF);
        rd(ACount); check("wrap2", obs_rd, 32'd0);
        rd(ACount); check("wrap3", obs_rd, 32'd1);
        rd(AStatus); check("wrap_pending", obs_rd, 32'd1);
        check("irq_masked", {31'd0, obs_irq}, 32'd0);
        wr(ACount, 32'd100);
        rd(ACount); check("count_wr_wins", obs_rd, 32'd100);

        // Reset mid-run
        wr(AStatus, 32'd1);
        wr(ACompare, 32'd2);
        wr(ACount, 32'd0);
        wr(ACtrl, 32'd3);
        for (int i = 0; i < 4; i++) idle();
        check("pre_reset_irq", {31'd0, obs_irq}, 32'd1);
        reset = 1'b0;
        wr(32'h20, 32'hCAFE_F00D);
        wr(ACompare, 32'd7);
        rd(32'h10); check("rst_rdata", obs_rd, 32'd0);
        check("rst_irq", {31'd0, obs_irq}, 32'd0);
        reset = 1'b1;
        rd(ACtrl);    check("post_ctrl", obs_rd, 32'd0);
        rd(ACount);   check("post_count", obs_rd, 32'd0);
        rd(ACompare); check("post_compare", obs_rd, 32'hFFFF_FFFF);
        rd(32'h10);   check("post_ram10", obs_rd, 32'hDEAD_BEEF);
        rd(32'h20);   check("post_ram20", obs_rd, 32'hCAFE_F00D);

        // Random traffic against the model
        for (int n = 0; n < 2000; n++) begin
            reset = ($urandom_range(0, 99) != 0);
            en    = ($urandom_range(0, 3) != 0);
            we    = $urandom_range(0, 1);
            d     = $urandom;
            case ($urandom_range(0, 3))
                0, 1: a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
                2: begin
                    a = TimerBase + 32'($urandom_range(0, 15));
                    if (a[3:2] != 2'd0) d = 32'($urandom_range(0, 12));
                end
                default: a = 32'h2000 + 32'($urandom_range(0, 4000));
            endcase
            if ($urandom_range(0, 49) == 0) a = 32'hFFC;
            access(en, we, a, d);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
